dmem_port_arbiter: RTL and testbench
====================================

# dmem_port_arbiter

Two-port arbiter and sequencer placed in front of the single-ported data memory. It shares the memory between the core memory stage (port C) and an auxiliary requester such as debug or DMA (port A). Each access is latched at grant and driven to memory with a hold-until-ready handshake. The block returns a completion pulse and read data to the owner, and generates the core busywait.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 255: cycles in ACCESS before abort; 0 disables the timeout.

Ports:
- clk_i  in  1  clock, all state on posedge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- core_req_i  in  1  core access valid; level, held until core_done_o.
- core_we_i  in  4  byte write enables; 0 means load.
- core_addr_i  in  30  word address [31:2].
- core_wdata_i  in  32  store data, already lane-aligned.
- core_rdata_o  out  32  load data; held until the next port C completion.
- core_done_o  out  1  one-cycle completion pulse.
- core_busywait_o  out  1  combinational: core_req_i & ~core_done_o.
- aux_req_i, aux_we_i, aux_addr_i, aux_wdata_i  in  1/4/30/32  port A, same semantics as port C.
- aux_rdata_o, aux_done_o  out  32/1  port A, same semantics as port C.
- mem_req_o  out  1  memory request; held high through ACCESS.
- mem_we_o  out  4  latched byte enables.
- mem_addr_o  out  30  latched word address.
- mem_wdata_o  out  32  latched store data.
- mem_rdata_i  in  32  read data; valid when mem_ready_i=1.
- mem_ready_i  in  1  access complete.
- err_o  out  1  high during DONE when the access timed out.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE -> ACCESS when any request is present. On that edge:
  - Latch owner, we, addr and wdata.
  - Clear the timeout counter.
- ACCESS:
  - mem_req_o=1; mem_* outputs are driven from the latches.
  - On mem_ready_i=1: capture mem_rdata_i into the owner's rdata_o, but only if the latched we==0. Go to DONE.
  - Otherwise the counter increments. At TIMEOUT_CYCLES-1 without ready, go to DONE with the timeout flag set. On a timed-out load, the owner's rdata_o is set to 0.
- DONE:
  - The owner's done_o=1; err_o = timeout flag.
  - Next state is always IDLE. No arbitration happens in DONE, so the still-high req of the finishing requester is never re-serviced.
- Arbitration: see Configuration. The last_grant register updates on every grant.
- Request fields may change freely before grant; they are ignored after grant until done.
- Dropping req before grant is legal. A request dropped after grant still completes and pulses done.
- mem_ready_i outside ACCESS is ignored.
- The non-owner port's rdata_o and done_o are unaffected by an access.

## Timing
- Reset (asynchronous, immediate) sets the following to 0:
  - every output except core_busywait_o;
  - FSM to IDLE;
  - last_grant to A, so C wins the first tie;
  - timeout counter and flag.
- Reset mid-ACCESS drops mem_req_o at once. No done is issued.
- Latency: req seen at edge N → mem_req_o high from N (registered on edge N). Ready sampled at edge M → done high during cycle M..M+1. The next grant is no earlier than edge M+2.
- Minimum turnaround is 3 cycles per access (IDLE, ACCESS with same-cycle ready, DONE).
- Timeout: with TIMEOUT_CYCLES=T>0, mem_req_o stays high for exactly T cycles, then one DONE cycle with err_o=1.
- core_busywait_o falls in the same cycle core_done_o rises.

## Configuration
- DMEM_ARB_ROUND_ROBIN_EN defined:
  - On simultaneous requests, grant the port that is not last_grant.
  - A single requester is always granted.
- Undefined:
  - Fixed priority: C always wins when both request; A is served only when core_req_i=0 in IDLE.
  - last_grant is not implemented.

## Test plan
- Core load, addr 0x100, memory ready after 3 ACCESS cycles with rdata 0xDEADBEEF → mem_req_o high 3 cycles; core_rdata_o=0xDEADBEEF; core_done_o pulses one cycle; busywait high until that pulse.
- Core store, we=4'b0011, wdata 0x0000A5A5 → mem_we_o=0011 while mem_req_o is high; core_rdata_o unchanged; aux outputs unchanged.
- Both ports request continuously with ready in 1 cycle:
  - with the macro: grants alternate C, A, C, A;
  - without it: C is granted every time and A never, until core_req_i drops.
- TIMEOUT_CYCLES=4, aux load, mem_ready_i never asserted → mem_req_o high 4 cycles, then aux_done_o=1, err_o=1, aux_rdata_o=0; FSM back in IDLE.
- rst_n_i pulsed low mid-ACCESS → mem_req_o falls without waiting for a clock edge; no done is issued. After release, a pending core request is granted on the first edge.
- Core changes addr 0x100→0x200 one cycle after grant → mem_addr_o stays 0x100 until DONE.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle for dmem_port_arbiter: core port (C), auxiliary port (A) and memory side.
// slave = arbiter view; master = environment view (requesters plus memory).
interface dmem_port_arbiter_if;
  logic        core_req_i;
  logic [3:0]  core_we_i;
  logic [29:0] core_addr_i;
  logic [31:0] core_wdata_i;
  logic [31:0] core_rdata_o;
  logic        core_done_o;
  logic        core_busywait_o;

  logic        aux_req_i;
  logic [3:0]  aux_we_i;
  logic [29:0] aux_addr_i;
  logic [31:0] aux_wdata_i;
  logic [31:0] aux_rdata_o;
  logic        aux_done_o;

  logic        mem_req_o;
  logic [3:0]  mem_we_o;
  logic [29:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ready_i;
  logic        err_o;

  modport slave (
    input  core_req_i, core_we_i, core_addr_i, core_wdata_i,
    input  aux_req_i, aux_we_i, aux_addr_i, aux_wdata_i,
    input  mem_rdata_i, mem_ready_i,
    output core_rdata_o, core_done_o, core_busywait_o,
    output aux_rdata_o, aux_done_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
  );

  modport master (
    output core_req_i, core_we_i, core_addr_i, core_wdata_i,
    output aux_req_i, aux_we_i, aux_addr_i, aux_wdata_i,
    output mem_rdata_i, mem_ready_i,
    input  core_rdata_o, core_done_o, core_busywait_o,
    input  aux_rdata_o, aux_done_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-port (core C / aux A) arbiter and sequencer in front of a single-ported data memory.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed priority to C.

// Per-port read-data holding register; keeps the last load result until the next capture.
module dmem_port_arbiter_ret (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cap_i,
  input  logic [31:0] data_i,
  output logic [31:0] rdata_o
);
  logic [31:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (cap_i) rdata_d = data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rdata_q <= '0;
    else          rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;
endmodule

module dmem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  dmem_port_arbiter_if.slave bus
);
  localparam int NUM_PORTS = 2;
  localparam int P_C       = 0;
  localparam int P_A       = 1;
  localparam int CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_e;

  typedef struct packed {
    logic [3:0]  we;
    logic [29:0] addr;
    logic [31:0] wdata;
  } mreq_t;

  state_e                         state_q, state_d;
  logic                           owner_q, owner_d;
  mreq_t                          lat_q, lat_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic                           to_q, to_d;

  logic [NUM_PORTS-1:0]           port_req;
  mreq_t [NUM_PORTS-1:0]          port_fld;
  logic [NUM_PORTS-1:0]           port_cap;
  logic [NUM_PORTS-1:0]           port_done;
  logic [NUM_PORTS-1:0][31:0]     port_rdata;
  logic [31:0]                    cap_data;
  logic                           grant_v;
  logic                           grant_p;

  assign port_req      = {bus.aux_req_i, bus.core_req_i};
  assign port_fld[P_C] = {bus.core_we_i, bus.core_addr_i, bus.core_wdata_i};
  assign port_fld[P_A] = {bus.aux_we_i, bus.aux_addr_i, bus.aux_wdata_i};

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  always_comb begin
    grant_v = |port_req;
    // on a tie, serve whichever port was not served last
    if (&port_req) grant_p = ~last_q;
    else           grant_p = port_req[P_A];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) last_q <= 1'b1;
    else          last_q <= last_d;
  end

  always_comb begin
    last_d = last_q;
    if (state_q == S_IDLE && grant_v) last_d = grant_p;
  end
`else
  always_comb begin
    grant_v = |port_req;
    grant_p = ~port_req[P_C];
  end
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      lat_q   <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      lat_q   <= lat_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    lat_d    = lat_q;
    cnt_d    = cnt_q;
    to_d     = to_q;
    port_cap = '0;
    cap_data = bus.mem_rdata_i;
    unique case (state_q)
      S_IDLE: begin
        if (grant_v) begin
          state_d = S_ACCESS;
          owner_d = grant_p;
          lat_d   = port_fld[grant_p];
          cnt_d   = '0;
          to_d    = 1'b0;
        end
      end
      S_ACCESS: begin
        if (bus.mem_ready_i) begin
          state_d           = S_DONE;
          port_cap[owner_q] = (lat_q.we == 4'h0);
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
          // a timed-out load returns zero rather than stale data
          state_d           = S_DONE;
          to_d              = 1'b1;
          port_cap[owner_q] = (lat_q.we == 4'h0);
          cap_data          = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign port_done[p] = (state_q == S_DONE) && (owner_q == 1'(p));

    dmem_port_arbiter_ret u_ret (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .cap_i   (port_cap[p]),
      .data_i  (cap_data),
      .rdata_o (port_rdata[p])
    );
  end

  assign bus.core_rdata_o    = port_rdata[P_C];
  assign bus.core_done_o     = port_done[P_C];
  assign bus.core_busywait_o = bus.core_req_i & ~port_done[P_C];
  assign bus.aux_rdata_o     = port_rdata[P_A];
  assign bus.aux_done_o      = port_done[P_A];

  assign bus.mem_req_o   = (state_q == S_ACCESS);
  assign bus.mem_we_o    = lat_q.we;
  assign bus.mem_addr_o  = lat_q.addr;
  assign bus.mem_wdata_o = lat_q.wdata;
  assign bus.err_o       = (state_q == S_DONE) && to_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter (TIMEOUT_CYCLES=4): transaction table plus
// hand sequences for arbitration, asynchronous reset and post-grant field changes.
module tb_dmem_port_arbiter;
  logic clk;
  logic rst_n;
  int   ncmp  = 0;
  int   nfail = 0;

  dmem_port_arbiter_if bus_if ();

  dmem_port_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          port;     // 0 = C, 1 = A
    logic [3:0]  we;
    logic [29:0] addr;
    logic [31:0] wdata;
    int          dly;      // ACCESS cycle in which ready is given; 0 = never
    logic [31:0] mdata;
    bit          chg;      // scramble request fields after grant
    int          exp_cyc;
    bit          exp_err;
    logic [31:0] exp_crd;
    logic [31:0] exp_ard;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_port(input bit port, input logic [3:0] we, input logic [29:0] addr,
                            input logic [31:0] wdata);
    if (!port) begin
      bus_if.core_we_i = we; bus_if.core_addr_i = addr; bus_if.core_wdata_i = wdata;
    end else begin
      bus_if.aux_we_i = we; bus_if.aux_addr_i = addr; bus_if.aux_wdata_i = wdata;
    end
  endtask

  // Called at a negedge; returns at a negedge with the arbiter idle.
  task automatic run_vec(input int i, input vec_t v);
    int ncyc = 0;
    bit done = 0, oth = 0, err = 0, fld_ok = 1, bw_ok = 1, idle_ok;
    bus_if.mem_ready_i = 1'b0;
    bus_if.mem_rdata_i = 32'h5A5A5A5A;
    drive_port(v.port, v.we, v.addr, v.wdata);
    if (!v.port) bus_if.core_req_i = 1'b1;
    else         bus_if.aux_req_i  = 1'b1;
    for (int k = 0; k < 16 && !done; k++) begin
      @(negedge clk);
      if (v.port ? bus_if.core_done_o : bus_if.aux_done_o) oth = 1;
      if (bus_if.mem_req_o) begin
        ncyc++;
        if (bus_if.mem_addr_o !== v.addr || bus_if.mem_we_o !== v.we ||
            bus_if.mem_wdata_o !== v.wdata) fld_ok = 0;
        if (!v.port && bus_if.core_busywait_o !== 1'b1) bw_ok = 0;
        if (v.chg && ncyc == 1) drive_port(v.port, v.we ^ 4'hF, v.addr ^ 30'h300, ~v.wdata);
        bus_if.mem_ready_i = (v.dly != 0 && ncyc == v.dly);
        bus_if.mem_rdata_i = bus_if.mem_ready_i ? v.mdata : 32'h5A5A5A5A;
      end else if (v.port ? bus_if.aux_done_o : bus_if.core_done_o) begin
        done = 1;
        err  = bus_if.err_o;
        if (bus_if.mem_addr_o !== v.addr) fld_ok = 0;
        if (!v.port && bus_if.core_busywait_o !== 1'b0) bw_ok = 0;
        bus_if.core_req_i  = 1'b0;
        bus_if.aux_req_i   = 1'b0;
        bus_if.mem_ready_i = 1'b0;
      end
    end
    @(negedge clk);
    idle_ok = !bus_if.mem_req_o && !bus_if.core_done_o && !bus_if.aux_done_o && !bus_if.err_o;
    chk($sformatf("v%0d.req_cycles", i), 32'(ncyc), 32'(v.exp_cyc));
    chk($sformatf("v%0d.done", i), 32'(done), 32'd1);
    chk($sformatf("v%0d.err", i), 32'(err), 32'(v.exp_err));
    chk($sformatf("v%0d.core_rdata", i), bus_if.core_rdata_o, v.exp_crd);
    chk($sformatf("v%0d.aux_rdata", i), bus_if.aux_rdata_o, v.exp_ard);
    chk($sformatf("v%0d.latched_fields", i), 32'(fld_ok), 32'd1);
    chk($sformatf("v%0d.other_done", i), 32'(oth), 32'd0);
    chk($sformatf("v%0d.busywait", i), 32'(bw_ok), 32'd1);
    chk($sformatf("v%0d.back_idle", i), 32'(idle_ok), 32'd1);
    drive_port(v.port, 4'h0, 30'h0, 32'h0);
  endtask

  initial begin
    logic [29:0] gaddr [5];
    int          gcyc  [5];
    logic [29:0] gexp  [4];
    int          ng;

    //          port we     addr           wdata         dly mdata         chg cyc err core_rd       aux_rd
    vecs[0] = '{1'b0, 4'h0, 30'h100,      32'h0,        3, 32'hDEADBEEF, 1'b1, 3, 1'b0, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 4'h3, 30'h40,       32'h0000A5A5, 1, 32'h12345678, 1'b0, 1, 1'b0, 32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b1, 4'h0, 30'h3FFFFFFF, 32'h0,        2, 32'hCAFEF00D, 1'b0, 2, 1'b0, 32'hDEADBEEF, 32'hCAFEF00D};
    vecs[3] = '{1'b1, 4'h0, 30'h55,       32'h0,        0, 32'h0,        1'b0, 4, 1'b1, 32'hDEADBEEF, 32'h0};
    vecs[4] = '{1'b0, 4'hF, 30'h66,       32'hFFFFFFFF, 0, 32'h0,        1'b0, 4, 1'b1, 32'hDEADBEEF, 32'h0};
    vecs[5] = '{1'b0, 4'h0, 30'h0,        32'h0,        4, 32'h0BADF00D, 1'b0, 4, 1'b0, 32'h0BADF00D, 32'h0};
    vecs[6] = '{1'b1, 4'h8, 30'h12,       32'h87654321, 1, 32'h11111111, 1'b0, 1, 1'b0, 32'h0BADF00D, 32'h0};

    rst_n = 1'b0;
    bus_if.core_req_i = 1'b1;
    bus_if.aux_req_i  = 1'b0;
    drive_port(1'b0, 4'h0, 30'h0, 32'h0);
    drive_port(1'b1, 4'h0, 30'h0, 32'h0);
    bus_if.mem_ready_i = 1'b0;
    bus_if.mem_rdata_i = 32'h0;
    #2;
    chk("reset.mem_req", 32'(bus_if.mem_req_o), 32'd0);
    chk("reset.core_done", 32'(bus_if.core_done_o), 32'd0);
    chk("reset.aux_done", 32'(bus_if.aux_done_o), 32'd0);
    chk("reset.err", 32'(bus_if.err_o), 32'd0);
    chk("reset.core_rdata", bus_if.core_rdata_o, 32'h0);
    chk("reset.aux_rdata", bus_if.aux_rdata_o, 32'h0);
    chk("reset.mem_addr", 32'(bus_if.mem_addr_o), 32'h0);
    chk("reset.busywait", 32'(bus_if.core_busywait_o), 32'd1);
    bus_if.core_req_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Arbitration: both ports request continuously, ready in the first ACCESS cycle.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    gexp[0] = 30'h10; gexp[1] = 30'h20; gexp[2] = 30'h10; gexp[3] = 30'h20;
`else
    gexp[0] = 30'h10; gexp[1] = 30'h10; gexp[2] = 30'h10; gexp[3] = 30'h10;
`endif
    for (int i = 0; i < 5; i++) begin gaddr[i] = '0; gcyc[i] = 0; end
    drive_port(1'b0, 4'h0, 30'h10, 32'h0);
    drive_port(1'b1, 4'h0, 30'h20, 32'h0);
    bus_if.core_req_i  = 1'b1;
    bus_if.aux_req_i   = 1'b1;
    bus_if.mem_ready_i = 1'b1;
    bus_if.mem_rdata_i = 32'h00000001;
    ng = 0;
    for (int k = 0; k < 40 && ng < 5; k++) begin
      @(negedge clk);
      if (bus_if.mem_req_o) begin
        gaddr[ng] = bus_if.mem_addr_o;
        gcyc[ng]  = k;
        ng++;
        if (ng == 4) bus_if.core_req_i = 1'b0;
      end
    end
    bus_if.aux_req_i = 1'b0;
    chk("arb.grant_count", 32'(ng), 32'd5);
    for (int i = 0; i < 4; i++)
      chk($sformatf("arb.grant%0d", i), 32'(gaddr[i]), 32'(gexp[i]));
    chk("arb.after_core_drop", 32'(gaddr[4]), 32'h20);
    chk("arb.turnaround", 32'(gcyc[1] - gcyc[0]), 32'd3);
    repeat (3) @(negedge clk);
    bus_if.mem_ready_i = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of an access.
    drive_port(1'b0, 4'h0, 30'h77, 32'h0);
    bus_if.core_req_i = 1'b1;
    @(negedge clk);
    chk("rst.granted", 32'(bus_if.mem_req_o), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst.req_drop_async", 32'(bus_if.mem_req_o), 32'd0);
    chk("rst.no_done_async", 32'(bus_if.core_done_o), 32'd0);
    @(negedge clk);
    chk("rst.no_done", 32'(bus_if.core_done_o), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.regrant", 32'(bus_if.mem_req_o), 32'd1);
    chk("rst.regrant_addr", 32'(bus_if.mem_addr_o), 32'h77);
    @(negedge clk);
    bus_if.mem_ready_i = 1'b1;
    bus_if.mem_rdata_i = 32'h600DCAFE;
    @(negedge clk);
    chk("rst.done_after", 32'(bus_if.core_done_o), 32'd1);
    chk("rst.rdata_after", bus_if.core_rdata_o, 32'h600DCAFE);
    bus_if.core_req_i  = 1'b0;
    bus_if.mem_ready_i = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", ncmp);
    $fatal(1);
  end
endmodule
